// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder: wait-stated RAM model with byte-lane stores
// and zero/sign-extended loads; responds WAIT_CYCLES+1 cycles after accept, takes requests only while idle.
module dm_responder #(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  BE,
   input  logic [31:0] wdata,
   input  logic [2:0]  ldsel,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);
   localparam int AW = DEPTH_LOG2 + 2;
   localparam logic [3:0] WC = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        we_q;
   logic [AW-1:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [2:0]  ldsel_q;
   logic [31:0] ld_q;
   logic        fault_q;

   logic [31:0] mem [2**DEPTH_LOG2];

   logic          enter_done;
   logic          a_we;
   logic [AW-1:0] a_addr;
   logic [3:0]    a_be;
   logic [31:0]   a_wdata;
   logic [2:0]    a_ldsel;
   logic          a_fault;
   logic [31:0]   a_ld;
   logic [31:0]   word;
   logic [15:0]   half;
   logic [7:0]    lane_b;
   logic          unused_hi;

   assign unused_hi  = ^addr[31:AW];
   assign enter_done = (state == IDLE && req && WC == 4'd0) || (state == WAIT && cnt <= 4'd1);

   // With zero wait states DONE is entered on the accept edge, so the access uses live inputs.
   always_comb begin
      a_we    = we_q;
      a_addr  = addr_q;
      a_be    = be_q;
      a_wdata = wdata_q;
      a_ldsel = ldsel_q;
      if (state == IDLE) begin
         a_we    = we;
         a_addr  = addr[AW-1:0];
         a_be    = BE;
         a_wdata = wdata;
         a_ldsel = ldsel;
      end
   end

   always_comb begin
      a_fault = 1'b0;
      if (a_we) begin
         a_fault = (a_be == 4'b0000);
      end else begin
         case (a_ldsel)
            3'b001, 3'b010: a_fault = a_addr[0];
            3'b011, 3'b100: a_fault = 1'b0;
            default:        a_fault = (a_addr[1:0] != 2'b00);
         endcase
      end
   end

   always_comb begin
      word = mem[a_addr[AW-1:2]];
      half = a_addr[1] ? word[31:16] : word[15:0];
      case (a_addr[1:0])
         2'd0:    lane_b = word[7:0];
         2'd1:    lane_b = word[15:8];
         2'd2:    lane_b = word[23:16];
         default: lane_b = word[31:24];
      endcase
      case (a_ldsel)
         3'b001:  a_ld = {16'h0000, half};
         3'b010:  a_ld = {{16{half[15]}}, half};
         3'b011:  a_ld = {24'h000000, lane_b};
         3'b100:  a_ld = {{24{lane_b[7]}}, lane_b};
         default: a_ld = word;
      endcase
      if (a_we || a_fault) a_ld = 32'h0;
   end

   // Reset wins over a commit on the same edge, so an interrupted store never lands.
   always_ff @(posedge clk) begin
      if (reset && enter_done && a_we && !a_fault) begin
         for (int i = 0; i < 4; i++) begin
            if (a_be[i]) mem[a_addr[AW-1:2]][8*i +: 8] <= a_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         ready <= 1'b0;
         err   <= 1'b0;
         busy  <= 1'b0;
         rdata <= 32'h0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         rdata <= 32'h0;
         if (enter_done) begin
            ld_q    <= a_ld;
            fault_q <= a_fault;
         end
         case (state)
            IDLE: begin
               if (req) begin
                  we_q    <= we;
                  addr_q  <= addr[AW-1:0];
                  be_q    <= BE;
                  wdata_q <= wdata;
                  ldsel_q <= ldsel;
                  cnt     <= WC;
                  busy    <= 1'b1;
                  state   <= (WC == 4'd0) ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (cnt <= 4'd1) begin
                  cnt   <= 4'd0;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               ready <= 1'b1;
               err   <= fault_q;
               rdata <= ld_q;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
